decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 171 +++++++++++++++++
 tb/tb_decode_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode pipeline register feeding register_file read ports and execute/writeback.
// Define DECODE_SCOREBOARD_EN to add the RAW/WAW pending-write scoreboard and issue stall.
module decode_stage (
   input  logic        clock,
   input  logic        reset,
   input  logic        instruction_valid,
   output logic        instruction_ready,
   input  logic [31:0] instruction,
   input  logic [31:0] pc,
   output logic        decode_valid,
   input  logic        decode_ready,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic        uses_rs1,
   output logic        uses_rs2,
   output logic [4:0]  register_write_select,
   output logic        register_write,
   output logic [31:0] immediate,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic        funct7_bit5,
   output logic [31:0] pc_out,
   output logic        illegal,
   input  logic        retire_valid,
   input  logic [4:0]  retire_select
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic [6:0]  d_opcode;
   logic [4:0]  d_rd;
   logic [4:0]  d_rs1;
   logic [4:0]  d_rs2;
   logic        d_uses_rs1;
   logic        d_uses_rs2;
   logic        d_writes_rd;
   logic        d_write;
   logic        d_illegal;
   logic [31:0] d_imm;
   logic        accept;
   logic        stall;

   assign d_opcode = instruction[6:0];
   assign d_rd     = instruction[11:7];
   assign d_rs1    = instruction[19:15];
   assign d_rs2    = instruction[24:20];

   always_comb begin
      d_uses_rs1  = 1'b0;
      d_uses_rs2  = 1'b0;
      d_writes_rd = 1'b0;
      d_illegal   = 1'b0;
      d_imm       = 32'h0;
      case (d_opcode)
         OP_R: begin
            d_uses_rs1  = 1'b1;
            d_uses_rs2  = 1'b1;
            d_writes_rd = 1'b1;
         end
         OP_IMM, OP_LOAD, OP_JALR: begin
            d_uses_rs1  = 1'b1;
            d_writes_rd = 1'b1;
            d_imm       = {{20{instruction[31]}}, instruction[31:20]};
         end
         OP_STORE: begin
            d_uses_rs1 = 1'b1;
            d_uses_rs2 = 1'b1;
            d_imm      = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
         end
         OP_BRANCH: begin
            d_uses_rs1 = 1'b1;
            d_uses_rs2 = 1'b1;
            d_imm      = {{19{instruction[31]}}, instruction[31], instruction[7],
                          instruction[30:25], instruction[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            d_writes_rd = 1'b1;
            d_imm       = {instruction[31:12], 12'h0};
         end
         OP_JAL: begin
            d_writes_rd = 1'b1;
            d_imm       = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                           instruction[20], instruction[30:21], 1'b0};
         end
         OP_FENCE, OP_SYSTEM: begin
         end
         default: d_illegal = 1'b1;
      endcase
   end

   // x0 is hardwired, so a write to it is never a real write (and never a hazard)
   assign d_write = d_writes_rd && (d_rd != 5'd0);

`ifdef DECODE_SCOREBOARD_EN
   logic [31:0] pending;
   logic [31:0] pending_next;

   assign stall = (d_uses_rs1 && pending[d_rs1]) ||
                  (d_uses_rs2 && pending[d_rs2]) ||
                  (d_write    && pending[d_rd]);

   // clear first so a same-index set in the same cycle wins
   always_comb begin
      pending_next = pending;
      if (retire_valid && (retire_select != 5'd0))
         pending_next[retire_select] = 1'b0;
      if (accept && d_write)
         pending_next[d_rd] = 1'b1;
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset)
         pending <= 32'h0;
      else
         pending <= pending_next;
   end
`else
   logic unused_retire;
   assign unused_retire = retire_valid ^ (|retire_select);
   assign stall = 1'b0;
`endif

   assign instruction_ready = !reset && (!decode_valid || decode_ready) && !stall;
   assign accept            = instruction_valid && instruction_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         decode_valid          <= 1'b0;
         rs1                   <= 5'd0;
         rs2                   <= 5'd0;
         uses_rs1              <= 1'b0;
         uses_rs2              <= 1'b0;
         register_write_select <= 5'd0;
         register_write        <= 1'b0;
         immediate             <= 32'h0;
         opcode                <= 7'd0;
         funct3                <= 3'd0;
         funct7_bit5           <= 1'b0;
         pc_out                <= 32'h0;
         illegal               <= 1'b0;
      end else if (accept) begin
         decode_valid          <= 1'b1;
         rs1                   <= d_rs1;
         rs2                   <= d_rs2;
         uses_rs1              <= d_uses_rs1;
         uses_rs2              <= d_uses_rs2;
         register_write_select <= d_rd;
         register_write        <= d_write;
         immediate             <= d_imm;
         opcode                <= d_opcode;
         funct3                <= instruction[14:12];
         funct7_bit5           <= instruction[30];
         pc_out                <= pc;
         illegal               <= d_illegal;
      end else if (decode_ready) begin
         decode_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; expectations follow DECODE_SCOREBOARD_EN when defined.
module tb_decode_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        instruction_valid;
   logic        instruction_ready;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        decode_valid;
   logic        decode_ready;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        uses_rs1;
   logic        uses_rs2;
   logic [4:0]  register_write_select;
   logic        register_write;
   logic [31:0] immediate;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7_bit5;
   logic [31:0] pc_out;
   logic        illegal;
   logic        retire_valid;
   logic [4:0]  retire_select;

   int tests  = 0;
   int failed = 0;

   always #5 clock = ~clock;

   decode_stage dut (
      .clock(clock),
      .reset(reset),
      .instruction_valid(instruction_valid),
      .instruction_ready(instruction_ready),
      .instruction(instruction),
      .pc(pc),
      .decode_valid(decode_valid),
      .decode_ready(decode_ready),
      .rs1(rs1),
      .rs2(rs2),
      .uses_rs1(uses_rs1),
      .uses_rs2(uses_rs2),
      .register_write_select(register_write_select),
      .register_write(register_write),
      .immediate(immediate),
      .opcode(opcode),
      .funct3(funct3),
      .funct7_bit5(funct7_bit5),
      .pc_out(pc_out),
      .illegal(illegal),
      .retire_valid(retire_valid),
      .retire_select(retire_select)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic present(input logic [31:0] ins, input logic [31:0] addr);
      instruction_valid = 1'b1;
      instruction       = ins;
      pc                = addr;
      #1;
   endtask

   initial begin
      reset             = 1'b1;
      instruction_valid = 1'b1;
      instruction       = 32'h00500093;
      pc                = 32'h0;
      decode_ready      = 1'b1;
      retire_valid      = 1'b1;
      retire_select     = 5'd1;
      tick();
      tick();
      check("rst_ready", instruction_ready, 0);
      check("rst_valid", decode_valid, 0);
      check("rst_rw", register_write, 0);
      check("rst_imm", immediate, 0);
      check("rst_illegal", illegal, 0);
      check("rst_uses", {uses_rs1, uses_rs2}, 0);
      retire_valid = 1'b0;
      retire_select = 5'd0;
      reset = 1'b0;

      // addi x1,x0,5
      present(32'h00500093, 32'h100);
      check("addi_ready", instruction_ready, 1);
      tick();
      check("addi_valid", decode_valid, 1);
      check("addi_rs1", rs1, 0);
      check("addi_rd", register_write_select, 1);
      check("addi_rw", register_write, 1);
      check("addi_imm", immediate, 32'h5);
      check("addi_op", opcode, 7'h13);
      check("addi_pc", pc_out, 32'h100);
      check("addi_uses", {uses_rs1, uses_rs2}, 2'b10);

      // add x3,x1,x2 -- RAW on x1
      present(32'h002081B3, 32'h104);
`ifdef DECODE_SCOREBOARD_EN
      check("raw_stall", instruction_ready, 0);
      tick();
      check("raw_stall2", instruction_ready, 0);
      check("raw_valid_drop", decode_valid, 0);
      retire_valid  = 1'b1;
      retire_select = 5'd1;
      #1;
      check("retire_no_bypass", instruction_ready, 0);
      tick();
      retire_valid  = 1'b0;
      retire_select = 5'd0;
      #1;
      check("retire_unblock", instruction_ready, 1);
`else
      check("nosb_ready", instruction_ready, 1);
`endif
      tick();
      check("add_valid", decode_valid, 1);
      check("add_rs", {rs1, rs2}, {5'd1, 5'd2});
      check("add_rd", register_write_select, 3);
      check("add_rw", register_write, 1);
      check("add_uses", {uses_rs1, uses_rs2}, 2'b11);
      check("add_imm", immediate, 0);
      check("add_op", opcode, 7'h33);
      check("add_pc", pc_out, 32'h104);

      // sw x2,-4(x1)
      present(32'hFE20AE23, 32'h108);
      tick();
      check("sw_rs", {rs1, rs2}, {5'd1, 5'd2});
      check("sw_rw", register_write, 0);
      check("sw_imm", immediate, 32'hFFFFFFFC);
      check("sw_f3", funct3, 3'd2);

      // lui x5,0x12345
      present(32'h123452B7, 32'h10C);
      tick();
      check("lui_rd", register_write_select, 5);
      check("lui_rw", register_write, 1);
      check("lui_imm", immediate, 32'h12345000);
      check("lui_uses", {uses_rs1, uses_rs2}, 2'b00);

      present(32'h00000000, 32'h110);
      tick();
      check("ill_flag", illegal, 1);
      check("ill_rw", register_write, 0);
      check("ill_imm", immediate, 0);

      // addi x0,x0,0: writes to x0 are suppressed
      present(32'h00000013, 32'h114);
      tick();
      check("nop_rw", register_write, 0);
      check("nop_illegal", illegal, 0);
      check("nop_rd", register_write_select, 0);

      // back-pressure with beq x1,x2,8 waiting
      decode_ready = 1'b0;
      present(32'h00208463, 32'h118);
      for (int i = 0; i < 3; i++) begin
         check("bp_ready", instruction_ready, 0);
         tick();
         check("bp_valid", decode_valid, 1);
         check("bp_op_hold", opcode, 7'h13);
         check("bp_pc_hold", pc_out, 32'h114);
      end
      decode_ready = 1'b1;
      #1;
      check("bp_release", instruction_ready, 1);
      tick();
      check("beq_op", opcode, 7'h63);
      check("beq_imm", immediate, 32'h8);
      check("beq_rs", {rs1, rs2}, {5'd1, 5'd2});
      check("beq_rw", register_write, 0);
      check("beq_pc", pc_out, 32'h118);

      // jal x6,-2
      present(32'hFFFFF36F, 32'h11C);
      tick();
      check("jal_imm", immediate, 32'hFFFFFFFE);
      check("jal_rd", register_write_select, 6);
      check("jal_rw", register_write, 1);

      // fence is a legal no-op
      present(32'h0000000F, 32'h120);
      tick();
      check("fence_illegal", illegal, 0);
      check("fence_rw", register_write, 0);
      check("fence_uses", {uses_rs1, uses_rs2}, 2'b00);

      // mid-run reset discards held instruction and pending writes to x3/x5/x6
      instruction_valid = 1'b0;
      decode_ready = 1'b0;
      reset = 1'b1;
      #1;
      check("mid_rst_ready", instruction_ready, 0);
      tick();
      check("mid_rst_valid", decode_valid, 0);
      check("mid_rst_imm", immediate, 0);
      check("mid_rst_op", opcode, 0);
      reset = 1'b0;
      decode_ready = 1'b1;
      present(32'h002081B3, 32'h200);
      check("post_rst_ready", instruction_ready, 1);
      tick();
      check("post_rst_valid", decode_valid, 1);
      check("post_rst_pc", pc_out, 32'h200);
      // lui x3 would be a WAW hazard if pending survived; x3 was just set again here
      present(32'h000011B7, 32'h204);
`ifdef DECODE_SCOREBOARD_EN
      check("waw_stall", instruction_ready, 0);
`else
      check("waw_nosb", instruction_ready, 1);
`endif
      instruction_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
